// File: rtl/wrapper_shared_pkg.sv
// -----------------------------------------------------------------------------
// wrapper_shared_pkg
// Shared definitions for the SPI master driver and the SPI slave/RAM wrapper:
// master FSM state enum, 2-bit command opcodes, frame length and the common
// payload width ADDR_SIZE.
// -----------------------------------------------------------------------------
package wrapper_shared_pkg;

  // Payload width shared by address and data bytes.
  localparam int ADDR_SIZE = 8;

  // One frame on MOSI carries {op, payload}.
  localparam int FRAME_LEN = 2 + ADDR_SIZE;

  // Width of the shared bit / wait / gap down-counter.
  localparam int CNT_W = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    M_IDLE  = 3'd0,
    M_CMD   = 3'd1,
    M_SHIFT = 3'd2,
    M_WAIT  = 3'd3,
    M_RECV  = 3'd4,
    M_GAP   = 3'd5
  } MSTATE_e;

  // Only a read-data command is followed by a reply phase on MISO.
  function automatic logic is_rd_data(input logic [1:0] op);
    logic res;
    case (op)
      OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR: res = 1'b0;
      OP_RD_DATA:                         res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/spi_master_shreg.sv
// -----------------------------------------------------------------------------
// spi_master_shreg
// Datapath of the SPI master: parallel-load / serial-out MOSI register,
// serial-in / parallel-out MISO register and the shared down-counter.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   load, load_word load the outgoing {op, payload} word
//   shift           advance the MOSI register by one bit (MSB first)
//   tx_bit          current MSB of the MOSI register
//   cnt_load/val    load the down-counter
//   cnt_dec         decrement the down-counter
//   cnt_zero        counter has reached zero
//   rx_en, miso     capture MISO at the bit position given by the counter
//   rx_word         received byte; bit 0 is the live MISO value so the final
//                   bit can be registered by the caller in the same cycle
// -----------------------------------------------------------------------------
module spi_master_shreg
  import wrapper_shared_pkg::*;
#(
  parameter int DATA_W  = ADDR_SIZE,
  parameter int FRAME_W = 2 + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_word,
  input  logic               shift,
  output logic               tx_bit,
  input  logic               cnt_load,
  input  logic [CNT_W-1:0]   cnt_val,
  input  logic               cnt_dec,
  output logic               cnt_zero,
  input  logic               rx_en,
  input  logic               miso,
  output logic [DATA_W-1:0]  rx_word
);

  logic [FRAME_W-1:0] tx;
  logic [CNT_W-1:0]   cnt;
  // Holds the first DATA_W-1 received bits; the last bit comes straight from miso.
  logic [DATA_W-2:0]  rx;

  // MOSI shift register: load on handshake, shift left one bit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx <= '0;
    end else if (load) begin
      tx <= load_word;
    end else if (shift) begin
      tx <= {tx[FRAME_W-2:0], 1'b0};
    end else begin
      tx <= tx;
    end
  end

  // Shared down-counter for shift, wait, receive and gap phases.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_load) begin
      cnt <= cnt_val;
    end else if (cnt_dec) begin
      cnt <= cnt - CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  // MISO capture: counter value k (k >= 1) stores into bit k-1, MSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx <= '0;
    end else if (rx_en) begin
      for (int i = 0; i < DATA_W - 1; i++) begin
        if (cnt == CNT_W'(i + 1)) begin
          rx[i] <= miso;
        end
      end
    end else begin
      rx <= rx;
    end
  end

  assign tx_bit   = tx[FRAME_W-1];
  assign cnt_zero = (cnt == '0);
  assign rx_word  = {rx, miso};

endmodule

// File: rtl/spi_master_drv.sv
// -----------------------------------------------------------------------------
// spi_master_drv
// SPI initiator driving the slave/RAM wrapper from a parallel command port.
// A command {cmd_op, cmd_data} is framed MSB-first on MOSI under SS_n, preceded
// by one select bit (cmd_op[1]). Read-data commands then wait RD_WAIT cycles
// and capture DATA_W bits from MISO, returned on rd_data with an rd_valid pulse.
// SS_n is held high IDLE_GAP cycles after every frame.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   cmd_valid/ready   command handshake (ready = engine idle)
//   cmd_op, cmd_data  opcode and payload, sampled on handshake only
//   rd_data, rd_valid last captured read byte and its one-cycle strobe
//   busy              frame in progress
//   seq_err           one-cycle pulse on a sequence violation
//   SS_n, MOSI, MISO  SPI pins (one bit per clk)
//
// Optional feature: define SPI_MASTER_SEQ_CHK_EN to drop data commands that
// are not preceded by an address command of the same direction (seq_err
// pulses, no frame is sent). Without it every command is framed and seq_err
// stays 0.
// -----------------------------------------------------------------------------
module spi_master_drv
  import wrapper_shared_pkg::*;
#(
  parameter int DATA_W   = ADDR_SIZE,
  parameter int RD_WAIT  = 1,
  parameter int IDLE_GAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              seq_err,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int FRAME_W = FRAME_LEN - ADDR_SIZE + DATA_W;

  // Counter reload values: a phase of N cycles runs the counter N-1 .. 0.
  localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);
  localparam logic [CNT_W-1:0] RECV_LOAD  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((IDLE_GAP > 1) ? IDLE_GAP - 1 : 0);

  MSTATE_e state, state_nx;

  logic              handshake;
  logic              seq_bad;
  logic              rd_frame, rd_frame_nx;
  logic              ss_n_nx, mosi_nx, ready_nx, rd_valid_nx, seq_err_nx;
  logic [DATA_W-1:0] rd_data_nx;

  logic              sr_load, sr_shift, sr_cnt_load, sr_cnt_dec, sr_rx_en;
  logic [CNT_W-1:0]  sr_cnt_val;
  logic              tx_bit, cnt_zero;
  logic [DATA_W-1:0] rx_word;

  assign handshake = cmd_valid && cmd_ready;

`ifdef SPI_MASTER_SEQ_CHK_EN
  logic wr_addr_ok, rd_addr_ok;

  assign seq_bad = ((cmd_op == OP_WR_DATA) && !wr_addr_ok) ||
                   ((cmd_op == OP_RD_DATA) && !rd_addr_ok);

  // Per-direction "address loaded" flags, updated on every accepted command.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_ok <= 1'b0;
      rd_addr_ok <= 1'b0;
    end else if (handshake) begin
      case (cmd_op)
        OP_WR_ADDR: wr_addr_ok <= 1'b1;
        OP_WR_DATA: wr_addr_ok <= 1'b0;
        OP_RD_ADDR: rd_addr_ok <= 1'b1;
        OP_RD_DATA: rd_addr_ok <= 1'b0;
        default: begin
          wr_addr_ok <= wr_addr_ok;
          rd_addr_ok <= rd_addr_ok;
        end
      endcase
    end else begin
      wr_addr_ok <= wr_addr_ok;
      rd_addr_ok <= rd_addr_ok;
    end
  end
`else
  assign seq_bad = 1'b0;
`endif

  spi_master_shreg #(
    .DATA_W  (DATA_W),
    .FRAME_W (FRAME_W)
  ) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (sr_load),
    .load_word ({cmd_op, cmd_data}),
    .shift     (sr_shift),
    .tx_bit    (tx_bit),
    .cnt_load  (sr_cnt_load),
    .cnt_val   (sr_cnt_val),
    .cnt_dec   (sr_cnt_dec),
    .cnt_zero  (cnt_zero),
    .rx_en     (sr_rx_en),
    .miso      (MISO),
    .rx_word   (rx_word)
  );

  // Next state plus next values of every registered output.
  always_comb begin
    state_nx    = state;
    rd_frame_nx = rd_frame;
    ss_n_nx     = 1'b1;
    mosi_nx     = 1'b0;
    ready_nx    = 1'b0;
    rd_valid_nx = 1'b0;
    rd_data_nx  = rd_data;
    seq_err_nx  = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_cnt_load = 1'b0;
    sr_cnt_val  = '0;
    sr_cnt_dec  = 1'b0;
    sr_rx_en    = 1'b0;
    case (state)
      M_IDLE: begin
        if (handshake) begin
          if (seq_bad) begin
            // Command consumed without a frame; stay ready.
            seq_err_nx = 1'b1;
            ready_nx   = 1'b1;
          end else begin
            state_nx    = M_CMD;
            ss_n_nx     = 1'b0;
            mosi_nx     = cmd_op[1];
            sr_load     = 1'b1;
            rd_frame_nx = is_rd_data(cmd_op);
          end
        end else begin
          ready_nx = 1'b1;
        end
      end
      M_CMD: begin
        state_nx    = M_SHIFT;
        ss_n_nx     = 1'b0;
        mosi_nx     = tx_bit;
        sr_shift    = 1'b1;
        sr_cnt_load = 1'b1;
        sr_cnt_val  = SHIFT_LOAD;
      end
      M_SHIFT: begin
        if (cnt_zero) begin
          sr_cnt_load = 1'b1;
          if (rd_frame) begin
            ss_n_nx = 1'b0;
            if (RD_WAIT == 0) begin
              state_nx   = M_RECV;
              sr_cnt_val = RECV_LOAD;
            end else begin
              state_nx   = M_WAIT;
              sr_cnt_val = WAIT_LOAD;
            end
          end else begin
            state_nx   = M_GAP;
            sr_cnt_val = GAP_LOAD;
          end
        end else begin
          ss_n_nx    = 1'b0;
          mosi_nx    = tx_bit;
          sr_shift   = 1'b1;
          sr_cnt_dec = 1'b1;
        end
      end
      M_WAIT: begin
        ss_n_nx = 1'b0;
        if (cnt_zero) begin
          state_nx    = M_RECV;
          sr_cnt_load = 1'b1;
          sr_cnt_val  = RECV_LOAD;
        end else begin
          sr_cnt_dec = 1'b1;
        end
      end
      M_RECV: begin
        sr_rx_en = 1'b1;
        if (cnt_zero) begin
          // Last MISO bit goes straight into rd_data; SS_n rises with rd_valid.
          state_nx    = M_GAP;
          rd_data_nx  = rx_word;
          rd_valid_nx = 1'b1;
          sr_cnt_load = 1'b1;
          sr_cnt_val  = GAP_LOAD;
        end else begin
          ss_n_nx    = 1'b0;
          sr_cnt_dec = 1'b1;
        end
      end
      M_GAP: begin
        if (cnt_zero) begin
          state_nx = M_IDLE;
          ready_nx = 1'b1;
        end else begin
          sr_cnt_dec = 1'b1;
        end
      end
      default: begin
        state_nx = M_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= M_IDLE;
      rd_frame  <= 1'b0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      seq_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      rd_frame  <= rd_frame_nx;
      SS_n      <= ss_n_nx;
      MOSI      <= mosi_nx;
      cmd_ready <= ready_nx;
      busy      <= (state_nx != M_IDLE);
      rd_valid  <= rd_valid_nx;
      rd_data   <= rd_data_nx;
      seq_err   <= seq_err_nx;
    end
  end

endmodule

// File: tb/tb_spi_master_drv.sv
// -----------------------------------------------------------------------------
// tb_spi_master_drv
// Directed bench for spi_master_drv (DATA_W=8, RD_WAIT=1, IDLE_GAP=1).
// A table of single-command frames with hand-computed MOSI streams and
// timing, plus hand-written sequences for reset, mid-frame reset,
// back-to-back commands and the read-data-after-reset case.
// -----------------------------------------------------------------------------
module tb_spi_master_drv;

  localparam int DW  = 8;
  localparam int RDW = 1;
  localparam int GAP = 1;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic          seq_err;
  logic          SS_n;
  logic          MOSI;
  logic          MISO;

  int n_cmp = 0;
  int n_err = 0;

  spi_master_drv #(
    .DATA_W   (DW),
    .RD_WAIT  (RDW),
    .IDLE_GAP (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .seq_err   (seq_err),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame record: expected MOSI is {select bit, op[1:0], data[7:0]};
  // cycle numbers are counted from the handshake cycle A (0 = none).
  typedef struct {
    logic [1:0]  op;
    logic [7:0]  data;
    logic [7:0]  reply;
    logic [10:0] exp_mosi;
    int          exp_ss_low;
    int          exp_rv_cyc;
    int          exp_ready_cyc;
    logic [7:0]  exp_rd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One command, slave reply driven on MISO inside the receive window.
  task automatic run_frame(input vec_t v, input string tag);
    int          waited;
    logic [10:0] stream;
    int          ss_low, rv_cyc, rv_cnt, rdy_cyc, quiet_bad, serr, rb;
    logic [7:0]  rd_at_rv;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 40) begin
      step();
      waited++;
    end
    chk({tag, " ready_before"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_data  = v.data;
    MISO      = 1'b1;
    stream    = '0;
    ss_low    = 0;
    rv_cyc    = 0;
    rv_cnt    = 0;
    rdy_cyc   = 0;
    quiet_bad = 0;
    serr      = 0;
    rd_at_rv  = '0;
    for (int k = 1; k <= 40 && rdy_cyc == 0; k++) begin
      step();
      if (k == 1) begin
        cmd_valid = 1'b0;
        cmd_op    = ~v.op;
        cmd_data  = ~v.data;
      end
      if (k <= 11) stream[11-k] = MOSI;
      else if (MOSI) quiet_bad++;
      if (!SS_n) ss_low++;
      if (rd_valid) begin
        rv_cnt++;
        if (rv_cyc == 0) begin
          rv_cyc   = k;
          rd_at_rv = rd_data;
        end
      end
      if (seq_err) serr++;
      if (cmd_ready) rdy_cyc = k;
      rb = k - (12 + RDW);
      if (rb >= 0 && rb < 8) MISO = v.reply[7-rb];
      else MISO = 1'b1;
    end
    chk({tag, " mosi"}, {21'd0, stream}, {21'd0, v.exp_mosi});
    chk({tag, " ss_low"}, ss_low, v.exp_ss_low);
    chk({tag, " rv_cyc"}, rv_cyc, v.exp_rv_cyc);
    chk({tag, " rv_cnt"}, rv_cnt, (v.exp_rv_cyc != 0) ? 1 : 0);
    if (v.exp_rv_cyc != 0) chk({tag, " rd_at_rv"}, {24'd0, rd_at_rv}, {24'd0, v.exp_rd});
    chk({tag, " ready_cyc"}, rdy_cyc, v.exp_ready_cyc);
    chk({tag, " mosi_quiet"}, quiet_bad, 0);
    chk({tag, " seq_err"}, serr, 0);
    chk({tag, " busy_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, " rd_data"}, {24'd0, rd_data}, {24'd0, v.exp_rd});
  endtask

  vec_t        vecs[11];
  vec_t        tmp;
  logic        ss_hist[80];
  logic        mosi_hist[80];
  logic [1:0]  b2b_op[3];
  logic [7:0]  b2b_dat[3];
  logic [10:0] b2b_exp[3];

  initial begin
    // op, data, reply, MOSI stream, SS_n low cycles, rd_valid cycle, ready cycle, rd_data after
    vecs[0]  = '{2'b00, 8'h3C, 8'h00, 11'h03C, 11, 0, 13, 8'h00};
    vecs[1]  = '{2'b01, 8'hA5, 8'h00, 11'h1A5, 11, 0, 13, 8'h00};
    vecs[2]  = '{2'b10, 8'h3C, 8'h00, 11'h63C, 11, 0, 13, 8'h00};
    vecs[3]  = '{2'b11, 8'h00, 8'hA5, 11'h700, 20, 21, 22, 8'hA5};
    vecs[4]  = '{2'b10, 8'h00, 8'h00, 11'h600, 11, 0, 13, 8'hA5};
    vecs[5]  = '{2'b11, 8'h81, 8'h5A, 11'h781, 20, 21, 22, 8'h5A};
    vecs[6]  = '{2'b00, 8'hFF, 8'h00, 11'h0FF, 11, 0, 13, 8'h5A};
    vecs[7]  = '{2'b10, 8'h3C, 8'h00, 11'h63C, 11, 0, 13, 8'h5A};
    vecs[8]  = '{2'b11, 8'h55, 8'h00, 11'h755, 20, 21, 22, 8'h00};
    vecs[9]  = '{2'b10, 8'h12, 8'h00, 11'h612, 11, 0, 13, 8'h00};
    vecs[10] = '{2'b11, 8'hFF, 8'hFF, 11'h7FF, 20, 21, 22, 8'hFF};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    MISO      = 1'b0;
    repeat (3) step();
    chk("rst SS_n", {31'd0, SS_n}, 32'd1);
    chk("rst MOSI", {31'd0, MOSI}, 32'd0);
    chk("rst cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst seq_err", {31'd0, seq_err}, 32'd0);
    chk("rst rd_data", {24'd0, rd_data}, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst cmd_ready", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 11; i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset at A+15 of a read-data frame.
    tmp = '{2'b10, 8'h3C, 8'h00, 11'h63C, 11, 0, 13, 8'hFF};
    run_frame(tmp, "rst_pre_addr");
    begin
      int rv_cnt, rd_nz, ss_low, rdy_j;
      cmd_valid = 1'b1;
      cmd_op    = 2'b11;
      cmd_data  = 8'h00;
      MISO      = 1'b1;
      for (int k = 1; k <= 15; k++) begin
        step();
        if (k == 1) cmd_valid = 1'b0;
        MISO = (k >= 13) ? 1'b1 : 1'b0;
        if (k == 15) rst = 1'b1;
      end
      step();
      chk("midrst SS_n", {31'd0, SS_n}, 32'd1);
      chk("midrst rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("midrst rd_data", {24'd0, rd_data}, 32'd0);
      chk("midrst busy", {31'd0, busy}, 32'd0);
      chk("midrst cmd_ready", {31'd0, cmd_ready}, 32'd0);
      rst    = 1'b0;
      rv_cnt = 0;
      rd_nz  = 0;
      ss_low = 0;
      rdy_j  = 0;
      for (int j = 1; j <= 20; j++) begin
        step();
        if (rd_valid) rv_cnt++;
        if (rd_data != 8'h00) rd_nz++;
        if (!SS_n) ss_low++;
        if (cmd_ready && rdy_j == 0) rdy_j = j;
      end
      chk("midrst rv_after", rv_cnt, 0);
      chk("midrst rd_stays0", rd_nz, 0);
      chk("midrst ss_after", ss_low, 0);
      chk("midrst ready_cyc", rdy_j, 1);
    end

    // Back-to-back: cmd_valid held, three commands, none dropped.
`ifdef SPI_MASTER_SEQ_CHK_EN
    b2b_op[0] = 2'b00; b2b_op[1] = 2'b01; b2b_op[2] = 2'b00;
    b2b_exp[0] = 11'h011; b2b_exp[1] = 11'h122; b2b_exp[2] = 11'h033;
`else
    b2b_op[0] = 2'b01; b2b_op[1] = 2'b01; b2b_op[2] = 2'b01;
    b2b_exp[0] = 11'h111; b2b_exp[1] = 11'h122; b2b_exp[2] = 11'h133;
`endif
    b2b_dat[0] = 8'h11; b2b_dat[1] = 8'h22; b2b_dat[2] = 8'h33;
    begin
      int          issued, nfr, pos, highs;
      logic        prev;
      logic [10:0] fs[3];
      int          flen[3];
      int          gaps[3];
      issued = 0;
      for (int c = 0; c < 80; c++) begin
        ss_hist[c]   = SS_n;
        mosi_hist[c] = MOSI;
        if (cmd_ready) begin
          if (issued < 3) begin
            cmd_valid = 1'b1;
            cmd_op    = b2b_op[issued];
            cmd_data  = b2b_dat[issued];
            issued++;
          end else begin
            cmd_valid = 1'b0;
          end
        end
        step();
      end
      cmd_valid = 1'b0;
      nfr   = 0;
      pos   = 0;
      highs = 0;
      prev  = 1'b1;
      for (int i = 0; i < 3; i++) begin
        fs[i]   = '0;
        flen[i] = 0;
        gaps[i] = 0;
      end
      for (int c = 0; c < 80; c++) begin
        if (!ss_hist[c]) begin
          if (prev) begin
            if (nfr >= 1 && nfr < 3) gaps[nfr] = highs;
            nfr++;
            pos = 0;
          end
          if (nfr <= 3 && pos < 11) fs[nfr-1][10-pos] = mosi_hist[c];
          pos++;
          if (nfr <= 3) flen[nfr-1] = pos;
          highs = 0;
        end else begin
          highs++;
        end
        prev = ss_hist[c];
      end
      chk("b2b frames", nfr, 3);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("b2b mosi%0d", i), {21'd0, fs[i]}, {21'd0, b2b_exp[i]});
        chk($sformatf("b2b len%0d", i), flen[i], 11);
      end
      // SS_n high for the gap cycles plus the idle/handshake cycle.
      chk("b2b gap1", gaps[1], GAP + 1);
      chk("b2b gap2", gaps[2], GAP + 1);
    end

    // Read-data as the first command after reset.
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
`ifdef SPI_MASTER_SEQ_CHK_EN
    chk("seq ready_before", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_data  = 8'h00;
    step();
    cmd_valid = 1'b0;
    chk("seq seq_err_a1", {31'd0, seq_err}, 32'd1);
    chk("seq SS_n_a1", {31'd0, SS_n}, 32'd1);
    chk("seq ready_a1", {31'd0, cmd_ready}, 32'd1);
    chk("seq busy_a1", {31'd0, busy}, 32'd0);
    step();
    chk("seq seq_err_a2", {31'd0, seq_err}, 32'd0);
    chk("seq SS_n_a2", {31'd0, SS_n}, 32'd1);
`else
    tmp = '{2'b11, 8'h00, 8'h3C, 11'h700, 20, 21, 22, 8'h3C};
    run_frame(tmp, "rd_after_rst");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
